// File: rtl/cmd_ram_pkg.sv
// cmd_ram_pkg: opcode encoding and frame field positions shared by cmd_ram.
package cmd_ram_pkg;
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_op_e;
  localparam int OP_W = 2;
  function automatic int op_lo(int data_w);
    return data_w;
  endfunction
  function automatic int op_hi(int data_w);
    return data_w + OP_W - 1;
  endfunction
endpackage

// File: rtl/cmd_ram_if.sv
// cmd_ram_if: frame input, read-return handshake and error flag of cmd_ram.
interface cmd_ram_if #(parameter int DATA_W = 8) ();
  logic              rx_valid;
  logic [DATA_W+1:0] din;
  logic              rx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              tx_ready;
  logic              addr_err;
  modport master (output rx_valid, din, tx_ready, input rx_ready, dout, tx_valid, addr_err);
  modport slave  (input rx_valid, din, tx_ready, output rx_ready, dout, tx_valid, addr_err);
endinterface

// File: rtl/cmd_ram_mem.sv
// cmd_ram_mem: DEPTH x DATA_W array, synchronous write, registered read, no reset.
module cmd_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cmd_ram.sv
// cmd_ram: opcode-framed RAM with separate write/read pointers, optional burst
// post-increment, valid/ready read return and a sticky out-of-range flag.
module cmd_ram
  import cmd_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AUTO_INC = 1
) (
  input logic      clk,
  input logic      rst,
  cmd_ram_if.slave bus
);
  localparam int OP_LO = op_lo(DATA_W);
  localparam int OP_HI = op_hi(DATA_W);
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  cmd_op_e           op;
  logic [DATA_W-1:0] payload, rdata;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic              acc, wr_acc, rd_acc, wr_oor, rd_oor, tx_valid, zero, err;
  function automatic logic [ADDR_W-1:0] bump(logic [ADDR_W-1:0] p);
    return p == LAST ? '0 : p + ADDR_W'(1);
  endfunction
  assign op           = cmd_op_e'(bus.din[OP_HI:OP_LO]);
  assign payload      = bus.din[DATA_W-1:0];
  assign bus.rx_ready = !tx_valid || bus.tx_ready;
  assign acc          = bus.rx_valid && bus.rx_ready;
  assign wr_acc       = acc && op == WR_DATA;
  assign rd_acc       = acc && op == RD_DATA;
  assign wr_oor       = {1'b0, wr_ptr} >= LIM;
  assign rd_oor       = {1'b0, rd_ptr} >= LIM;
  always_comb begin
    wr_nxt = (acc && op == WR_ADDR) ? payload[ADDR_W-1:0] : (wr_acc && AUTO_INC != 0) ? bump(wr_ptr) : wr_ptr;
    rd_nxt = (acc && op == RD_ADDR) ? payload[ADDR_W-1:0] : (rd_acc && AUTO_INC != 0) ? bump(rd_ptr) : rd_ptr;
  end
  // zero forces dout low after reset and for out-of-range reads, since the array has no reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_valid <= 1'b0;
      zero     <= 1'b1;
      err      <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      tx_valid <= rd_acc || (tx_valid && !bus.tx_ready);
      if (rd_acc) zero <= rd_oor;
      if ((wr_acc && wr_oor) || (rd_acc && rd_oor)) err <= 1'b1;
    end
  end
  cmd_ram_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (wr_acc && !wr_oor),
    .waddr(wr_ptr),
    .wdata(payload),
    .re   (rd_acc && !rd_oor),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  assign bus.dout     = zero ? '0 : rdata;
  assign bus.tx_valid = tx_valid;
  assign bus.addr_err = err;
endmodule

// File: tb/tb_cmd_ram.sv
// tb_cmd_ram: three cmd_ram variants on shared random and directed stimulus, checked against a behavioural model.
module tb_cmd_ram;
  import cmd_ram_pkg::*;
  logic clk = 0, rst = 0, rx_valid = 0, tx_ready = 1;
  logic [9:0] din = '0;
  always #5 clk = ~clk;
  cmd_ram_if b0 (), b1 (), b2 ();
  assign b0.rx_valid = rx_valid; assign b0.din = din; assign b0.tx_ready = tx_ready;
  assign b1.rx_valid = rx_valid; assign b1.din = din; assign b1.tx_ready = tx_ready;
  assign b2.rx_valid = rx_valid; assign b2.din = din; assign b2.tx_ready = tx_ready;
  cmd_ram #(.DEPTH(256), .AUTO_INC(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  cmd_ram #(.DEPTH(200), .AUTO_INC(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  cmd_ram #(.DEPTH(256), .AUTO_INC(0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  logic [7:0] dv [3];
  logic       tv [3], rr [3], ae [3];
  assign dv[0] = b0.dout; assign tv[0] = b0.tx_valid; assign rr[0] = b0.rx_ready; assign ae[0] = b0.addr_err;
  assign dv[1] = b1.dout; assign tv[1] = b1.tx_valid; assign rr[1] = b1.rx_ready; assign ae[1] = b1.addr_err;
  assign dv[2] = b2.dout; assign tv[2] = b2.tx_valid; assign rr[2] = b2.rx_ready; assign ae[2] = b2.addr_err;

  int checks = 0, errors = 0;
  int D [3] = '{256, 200, 256};
  int A [3] = '{1, 1, 0};
  int wr [3], rd [3], md [3];
  bit txv [3], dk [3], err [3];
  int mem [3][256];
  bit known [3][256];
  bit last_acc;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int nxt(int p, int d);
    return p == d - 1 ? 0 : (p + 1) % 256;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      wr[k] = 0; rd[k] = 0; txv[k] = 0; md[k] = 0; dk[k] = 1; err[k] = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    int op, p;
    acc = rx_valid && (!txv[0] || tx_ready);
    last_acc = acc;
    op = int'(din[9:8]);
    p = int'(din[7:0]);
    for (int k = 0; k < 3; k++) begin
      if (txv[k] && tx_ready) txv[k] = 0;
      if (acc) begin
        if (op == 0) wr[k] = p;
        else if (op == 2) rd[k] = p;
        else if (op == 1) begin
          if (wr[k] < D[k]) begin mem[k][wr[k]] = p; known[k][wr[k]] = 1; end
          else err[k] = 1;
          if (A[k] != 0) wr[k] = nxt(wr[k], D[k]);
        end else begin
          txv[k] = 1;
          if (rd[k] < D[k]) begin md[k] = mem[k][rd[k]]; dk[k] = known[k][rd[k]]; end
          else begin md[k] = 0; dk[k] = 1; err[k] = 1; end
          if (A[k] != 0) rd[k] = nxt(rd[k], D[k]);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step(); else last_acc = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] p);
    rx_valid = 1;
    din = {op, p};
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (last_acc) break;
    end
    if (!last_acc) begin
      errors++;
      $display("FAIL send_timeout op %0d payload %0h not accepted within 20 cycles", op, p);
    end
    rx_valid = 0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.tx_valid", k), 32'(tv[k]), 32'(txv[k]));
      chk($sformatf("u%0d.rx_ready", k), 32'(rr[k]), 32'(!txv[k] || tx_ready));
      chk($sformatf("u%0d.addr_err", k), 32'(ae[k]), 32'(err[k]));
      if (txv[k] && dk[k]) chk($sformatf("u%0d.dout", k), 32'(dv[k]), 32'(md[k]));
    end
  end

  initial begin
    #1 rst = 1;
    model_reset();
    #1;
    chk("rst.dout", 32'(dv[0]), 32'h0);
    chk("rst.tx_valid", 32'(tv[0]), 32'h0);
    chk("rst.addr_err", 32'(ae[0]), 32'h0);
    chk("rst.rx_ready", 32'(rr[0]), 32'h1);
    cyc(); cyc();
    rst = 0;
    send(WR_ADDR, 8'h10); send(WR_DATA, 8'hA5); send(WR_DATA, 8'h5A);
    send(RD_ADDR, 8'h10); send(RD_DATA, 8'h00);
    chk("t1.dout", 32'(dv[0]), 32'hA5);
    chk("t1.tx_valid", 32'(tv[0]), 32'h1);
    chk("t1.noinc_dout", 32'(dv[2]), 32'h5A);
    cyc();
    chk("t1.pulse_end", 32'(tv[0]), 32'h0);
    chk("t1.addr_err", 32'(ae[0]), 32'h0);
    send(WR_ADDR, 8'hFE); send(WR_DATA, 8'h11); send(WR_DATA, 8'h22); send(WR_DATA, 8'h33);
    send(RD_ADDR, 8'hFE);
    send(RD_DATA, 8'h00); chk("burst.rd0", 32'(dv[0]), 32'h11);
    send(RD_DATA, 8'h00); chk("burst.rd1", 32'(dv[0]), 32'h22);
    send(RD_DATA, 8'h00); chk("burst.rd2_wrap", 32'(dv[0]), 32'h33);
    cyc();
    chk("burst.u0_err", 32'(ae[0]), 32'h0);
    chk("burst.u1_err", 32'(ae[1]), 32'h1);
    send(RD_ADDR, 8'h10);
    tx_ready = 0;
    send(RD_DATA, 8'h00);
    chk("arst.pre_dout", 32'(dv[0]), 32'hA5);
    #2 rst = 1;
    model_reset();
    #1;
    chk("arst.tx_valid", 32'(tv[0]), 32'h0);
    chk("arst.dout", 32'(dv[0]), 32'h0);
    chk("arst.u1_err", 32'(ae[1]), 32'h0);
    chk("arst.rx_ready", 32'(rr[0]), 32'h1);
    cyc();
    rst = 0;
    tx_ready = 1;
    send(RD_DATA, 8'h00);
    chk("arst.rd_ptr0", 32'(dv[0]), 32'h33);
    send(WR_DATA, 8'h77); send(RD_ADDR, 8'h00); send(RD_DATA, 8'h00);
    chk("arst.wr_ptr0", 32'(dv[0]), 32'h77);
    send(RD_ADDR, 8'h10);
    tx_ready = 0;
    send(RD_DATA, 8'h00);
    rx_valid = 1;
    din = {RD_DATA, 8'h00};
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp.rx_ready", 32'(rr[0]), 32'h0);
      chk("bp.dout_hold", 32'(dv[0]), 32'hA5);
    end
    tx_ready = 1;
    cyc();
    chk("bp.next_word", 32'(dv[0]), 32'h5A);
    chk("bp.still_valid", 32'(tv[0]), 32'h1);
    rx_valid = 0;
    cyc();
    chk("bp.drained", 32'(tv[0]), 32'h0);
    send(WR_ADDR, 8'hC8); send(WR_DATA, 8'h55);
    cyc();
    chk("oor.u1_err", 32'(ae[1]), 32'h1);
    chk("oor.u0_err", 32'(ae[0]), 32'h0);
    send(RD_ADDR, 8'hC8); send(RD_DATA, 8'h00);
    chk("oor.u1_dout", 32'(dv[1]), 32'h0);
    chk("oor.u1_valid", 32'(tv[1]), 32'h1);
    chk("oor.u0_dout", 32'(dv[0]), 32'h55);
    send(RD_ADDR, 8'h10); send(RD_DATA, 8'h00);
    chk("oor.u1_mem_intact", 32'(dv[1]), 32'hA5);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] p;
      r = $urandom_range(0, 3);
      p = r == 0 ? 8'($urandom) : r == 1 ? 8'($urandom_range(190, 210)) :
          r == 2 ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 5));
      rx_valid = $urandom_range(0, 3) != 0;
      din = {2'($urandom), p};
      tx_ready = $urandom_range(0, 3) != 0;
      if (i == 1500) begin
        #2 rst = 1;
        model_reset();
        cyc();
        rst = 0;
      end
      cyc();
    end
    rx_valid = 0;
    tx_ready = 1;
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
